// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and halt-opcode decode.
package arisc_pkg;

    localparam int W_OPCODE = 4;
    localparam logic [W_OPCODE-1:0] OP_HALT = 4'h0;

    typedef enum logic [2:0] {
        S_LO,
        S_HI,
        S_WR,
        S_START,
        S_BUSY,
        S_WAIT,
        S_DUMP,
        S_DONE
    } state_t;

    function automatic logic is_halt(input logic [W_OPCODE-1:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-wide valid/ready channel, used for the host byte stream and the optional DRAM dump stream.
interface prog_loader_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prog_loader_dram_dumper.sv
// Streams every DRAM byte out in address order (only built with DRAM_DUMP_EN).
// Each byte takes read, capture and send phases because the DRAM read has one cycle of latency.
`ifdef DRAM_DUMP_EN
module dram_dumper #(
    parameter int W_ADDR = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    output logic              fin,
    output logic [W_ADDR-1:0] dump_addr,
    input  logic [7:0]        dram_dout,
    prog_loader_if.master     m
);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_RD   = 2'd1;
    localparam logic [1:0] D_CAP  = 2'd2;
    localparam logic [1:0] D_SEND = 2'd3;
    localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(DEPTH - 1);

    logic [1:0] phase;

    // m.data is only loaded in D_CAP, so it stays stable while the host stalls m.ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase     <= D_IDLE;
            dump_addr <= '0;
            m.valid   <= 1'b0;
            m.data    <= '0;
            fin       <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (phase)
                D_IDLE: begin
                    if (go) begin
                        dump_addr <= '0;
                        phase     <= D_RD;
                    end
                end
                D_RD: phase <= D_CAP;
                D_CAP: begin
                    m.data  <= dram_dout;
                    m.valid <= 1'b1;
                    phase   <= D_SEND;
                end
                D_SEND: begin
                    if (m.ready) begin
                        m.valid <= 1'b0;
                        if (dump_addr == LAST_ADDR) begin
                            fin   <= 1'b1;
                            phase <= D_IDLE;
                        end else begin
                            dump_addr <= dump_addr + 1'b1;
                            phase     <= D_RD;
                        end
                    end
                end
                default: phase <= D_IDLE;
            endcase
        end
    end

endmodule
`endif

// File: rtl/prog_loader.sv
// Boot loader: packs host bytes into 16-bit words, fills IRAM up to the halt word, runs the cpu.
// Define DRAM_DUMP_EN to stream all DRAM bytes back to the host before flagging done.
module prog_loader
    import arisc_pkg::*;
#(
    parameter int W_INSTR = 16,
    parameter int W_ADDR  = 8,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rstn,
    prog_loader_if.slave       s,
    output logic               iram_write,
    output logic [W_ADDR-1:0]  iram_addr,
    output logic [W_INSTR-1:0] iram_din,
    output logic               start,
    input  logic               idle,
    output logic               done,
    output logic               err
`ifdef DRAM_DUMP_EN
    ,
    output logic               dump_active,
    output logic [W_ADDR-1:0]  dump_addr,
    input  logic [7:0]         dram_dout,
    prog_loader_if.master      m
`endif
);

    localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    state_t            after_wait;
    logic [7:0]        lo_byte;
    logic [W_ADDR-1:0] cnt;
    logic              hs;
    logic              dump_fin;

    assign hs = s.valid & s.ready;

`ifdef DRAM_DUMP_EN
    assign after_wait = S_DUMP;

    dram_dumper #(
        .W_ADDR (W_ADDR),
        .DEPTH  (DEPTH)
    ) u_dumper (
        .clk       (clk),
        .rstn      (rstn),
        .go        ((state == S_WAIT) && idle),
        .fin       (dump_fin),
        .dump_addr (dump_addr),
        .dram_dout (dram_dout),
        .m         (m)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dump_active <= 1'b0;
        end else begin
            dump_active <= (state_nx == S_DUMP);
        end
    end
`else
    assign after_wait = S_DONE;
    assign dump_fin   = 1'b0;
`endif

    // Idle is only looked at after start, so a cpu still idle in the start cycle is not mistaken for done
    always_comb begin
        state_nx = state;
        case (state)
            S_LO:    if (hs) state_nx = S_HI;
            S_HI:    if (hs) state_nx = S_WR;
            S_WR:    state_nx = (is_halt(lo_byte[W_OPCODE-1:0]) || cnt == LAST_ADDR) ? S_START : S_LO;
            S_START: state_nx = S_BUSY;
            S_BUSY:  if (!idle) state_nx = S_WAIT;
            S_WAIT:  if (idle) state_nx = after_wait;
            S_DUMP:  if (dump_fin) state_nx = S_DONE;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_LO;
        endcase
    end

    // Ready, start and done are registered from the next state so every output is a flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_LO;
            lo_byte    <= '0;
            cnt        <= '0;
            s.ready    <= 1'b0;
            iram_write <= 1'b0;
            iram_addr  <= '0;
            iram_din   <= '0;
            start      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            s.ready    <= (state_nx == S_LO) || (state_nx == S_HI);
            iram_write <= (state == S_HI) && hs;
            start      <= (state_nx == S_START);
            done       <= (state_nx == S_DONE);
            if (state == S_LO && hs) begin
                lo_byte <= s.data;
            end
            if (state == S_HI && hs) begin
                iram_din  <= {s.data, lo_byte};
                iram_addr <= cnt;
            end
            if (state == S_WR && !is_halt(lo_byte[W_OPCODE-1:0])) begin
                if (cnt == LAST_ADDR) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
